sys_array_cell: RTL and testbench

- Weight-stationary processing element (PE) of the systolic matrix-multiply array.
- Holds one signed parameter (weight) loaded through a column shift chain.
- Each cycle it multiplies the incoming activation by the held weight and adds the partial sum arriving from the neighbouring cell.
- Tiled as rows x columns in the array top.

---
 rtl/sys_array_pkg.sv | 13 +
 rtl/sys_array_cell_if.sv | 26 ++
 rtl/sys_array_mac.sv | 39 +++
 rtl/sys_array_cell.sv | 45 ++++
 tb/tb_sys_array_cell.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and constants for the systolic array processing elements.
package sys_array_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 2 * DATA_WIDTH_DEF;

  typedef logic signed [DATA_WIDTH_DEF-1:0] data_t;
  typedef logic signed [ACC_WIDTH_DEF-1:0]  acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/sys_array_cell_if.sv
// Data and weight-chain signals of one systolic array cell.
interface sys_array_cell_if
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH;

  logic                          param_load;
  logic signed [DATA_WIDTH-1:0]  input_data;
  logic signed [ACC_WIDTH-1:0]   prop_data;
  logic signed [DATA_WIDTH-1:0]  param_data;
  logic signed [ACC_WIDTH-1:0]   out_data;
  logic signed [DATA_WIDTH-1:0]  prop_param;

  modport master (
    output param_load, input_data, prop_data, param_data,
    input  out_data, prop_param
  );

  modport slave (
    input  param_load, input_data, prop_data, param_data,
    output out_data, prop_param
  );

endinterface

// File: rtl/sys_array_mac.sv
// Combinational signed multiply-add; SYS_ARRAY_CELL_SAT_EN selects a saturating adder
// instead of the default wrapping one.
module sys_array_mac
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0]   act,
  input  logic signed [DATA_WIDTH-1:0]   weight,
  input  logic signed [2*DATA_WIDTH-1:0] psum,
  output logic signed [2*DATA_WIDTH-1:0] mac_c
);

  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH;

  logic signed [ACC_WIDTH-1:0] prod_c;

  // A full-width signed product never overflows the accumulator width.
  assign prod_c = ACC_WIDTH'(act) * ACC_WIDTH'(weight);

`ifdef SYS_ARRAY_CELL_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_HI = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_LO = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_ext_c;

  // One guard bit: overflow shows up as disagreement between the top two bits.
  always_comb begin
    sum_ext_c = (ACC_WIDTH+1)'(psum) + (ACC_WIDTH+1)'(prod_c);
    mac_c     = sum_ext_c[ACC_WIDTH-1:0];
    if (sum_ext_c[ACC_WIDTH] != sum_ext_c[ACC_WIDTH-1]) begin
      mac_c = sum_ext_c[ACC_WIDTH] ? ACC_LO : ACC_HI;
    end
  end
`else
  assign mac_c = psum + prod_c;
`endif

endmodule

// File: rtl/sys_array_cell.sv
// Weight-stationary systolic PE: held weight, registered multiply-accumulate.
// Optional saturating accumulate via SYS_ARRAY_CELL_SAT_EN.
module sys_array_cell
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  sys_array_cell_if.slave  bus
);

  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] weight_q;
  logic signed [ACC_WIDTH-1:0]  out_q;
  logic signed [ACC_WIDTH-1:0]  mac_c;

  sys_array_mac #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .act    (bus.input_data),
    .weight (weight_q),
    .psum   (bus.prop_data),
    .mac_c  (mac_c)
  );

  // reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      weight_q <= '0;
      out_q    <= '0;
    end else begin
      if (bus.param_load) begin
        weight_q <= bus.param_data;
      end
      out_q <= mac_c;
    end
  end

  // The weight register feeds the next cell's load chain directly.
  assign bus.prop_param = weight_q;
  assign bus.out_data   = out_q;

endmodule

// File: tb/tb_sys_array_cell.sv
// Directed bench for sys_array_cell: reset, MAC, signed/overflow cases,
// load-during-MAC and a two-cell weight chain.
module tb_sys_array_cell;
  import sys_array_pkg::*;

  localparam int unsigned W  = DATA_WIDTH_DEF;
  localparam int unsigned AW = 2 * W;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  sys_array_cell_if #(.DATA_WIDTH(W)) u_if0 ();
  sys_array_cell_if #(.DATA_WIDTH(W)) u_if1 ();

  sys_array_cell #(.DATA_WIDTH(W)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if0.slave)
  );

  sys_array_cell #(.DATA_WIDTH(W)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if1.slave)
  );

  // Second cell sits behind the first in the weight load chain.
  assign u_if1.param_data = u_if0.prop_param;
  assign u_if1.param_load = u_if0.param_load;
  assign u_if1.input_data = '0;
  assign u_if1.prop_data  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input int pd, input int ind, input int prd);
    u_if0.param_load = ld;
    u_if0.param_data = W'(pd);
    u_if0.input_data = W'(ind);
    u_if0.prop_data  = AW'(prd);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    drive(1'b0, 0, 0, 0);
    #12;
    reset_n = 1'b0;
    drive(1'b1, 7, 1, 2);
    tick();
    drive(1'b0, 7, 1, 2);
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(9)) begin
      n_err++; $display("FAIL pre_reset_out got %0d want 9", u_if0.out_data);
    end
    n_cmp++;
    if (u_if0.prop_param !== W'(7)) begin
      n_err++; $display("FAIL pre_reset_param got %0d want 7", u_if0.prop_param);
    end
    #3;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (u_if0.out_data !== AW'(0) || u_if0.prop_param !== W'(0)) begin
      n_err++;
      $display("FAIL async_reset got out=%0d param=%0d want 0/0", u_if0.out_data, u_if0.prop_param);
    end
    drive(1'b1, 9, 3, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (u_if0.out_data !== AW'(0) || u_if0.prop_param !== W'(0)) begin
        n_err++;
        $display("FAIL reset_hold[%0d] got out=%0d param=%0d want 0/0", i, u_if0.out_data, u_if0.prop_param);
      end
    end
  endtask

  task automatic test_basic_mac();
    drive(1'b1, 5, 0, 0);
    reset_n = 1'b0;
    tick();
    drive(1'b0, 9, 1, 2);
    n_cmp++;
    if (u_if0.prop_param !== W'(5)) begin
      n_err++; $display("FAIL load_weight got %0d want 5", u_if0.prop_param);
    end
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(7)) begin
      n_err++; $display("FAIL mac_1 got %0d want 7", u_if0.out_data);
    end
    n_cmp++;
    if (u_if0.prop_param !== W'(5)) begin
      n_err++; $display("FAIL weight_hold got %0d want 5", u_if0.prop_param);
    end
    drive(1'b0, 0, 5, 2);
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(27)) begin
      n_err++; $display("FAIL mac_5 got %0d want 27", u_if0.out_data);
    end
  endtask

  task automatic test_signed();
    drive(1'b0, 0, -3, 2);
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(-13)) begin
      n_err++; $display("FAIL signed_neg got %0d want -13", u_if0.out_data);
    end
    drive(1'b1, -128, 0, 0);
    tick();
    drive(1'b0, 0, -128, 0);
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(16384)) begin
      n_err++; $display("FAIL signed_min_sq got %0d want 16384", u_if0.out_data);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_pos;
    logic [AW-1:0] exp_neg;
`ifdef SYS_ARRAY_CELL_SAT_EN
    exp_pos = AW'(32767);
    exp_neg = AW'(-32768);
`else
    exp_pos = AW'(-16640);
    exp_neg = AW'(16512);
`endif
    drive(1'b1, 127, 0, 0);
    tick();
    drive(1'b0, 0, 127, 32767);
    tick();
    n_cmp++;
    if (u_if0.out_data !== exp_pos) begin
      n_err++; $display("FAIL overflow_pos got %0d want %0d", u_if0.out_data, $signed(exp_pos));
    end
    drive(1'b0, 0, -128, -32768);
    tick();
    n_cmp++;
    if (u_if0.out_data !== exp_neg) begin
      n_err++; $display("FAIL overflow_neg got %0d want %0d", u_if0.out_data, $signed(exp_neg));
    end
  endtask

  task automatic test_load_during_mac();
    drive(1'b1, 5, 0, 0);
    tick();
    drive(1'b1, 3, 2, 0);
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(10)) begin
      n_err++; $display("FAIL load_mac_old got %0d want 10", u_if0.out_data);
    end
    n_cmp++;
    if (u_if0.prop_param !== W'(3)) begin
      n_err++; $display("FAIL load_mac_param got %0d want 3", u_if0.prop_param);
    end
    drive(1'b0, 0, 2, 0);
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(6)) begin
      n_err++; $display("FAIL load_mac_new got %0d want 6", u_if0.out_data);
    end
  endtask

  task automatic test_chain_shift();
    drive(1'b1, 4, 0, 0);
    tick();
    drive(1'b1, 9, 0, 0);
    tick();
    drive(1'b0, 0, 0, 0);
    n_cmp++;
    if (u_if1.prop_param !== W'(4)) begin
      n_err++; $display("FAIL chain_cell1 got %0d want 4", u_if1.prop_param);
    end
    n_cmp++;
    if (u_if0.prop_param !== W'(9)) begin
      n_err++; $display("FAIL chain_cell0 got %0d want 9", u_if0.prop_param);
    end
    #2;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (u_if0.prop_param !== W'(0) || u_if1.prop_param !== W'(0) || u_if1.out_data !== AW'(0)) begin
      n_err++;
      $display("FAIL chain_reset got p0=%0d p1=%0d o1=%0d want 0/0/0", u_if0.prop_param, u_if1.prop_param, u_if1.out_data);
    end
    tick();
    reset_n = 1'b0;
    drive(1'b0, 0, 3, 11);
    tick();
    n_cmp++;
    if (u_if0.out_data !== AW'(11)) begin
      n_err++; $display("FAIL post_reset_passthru got %0d want 11", u_if0.out_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic_mac();
    test_signed();
    test_overflow();
    test_load_during_mac();
    test_chain_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
